// File: rtl/branch_resolve_ctrl_if.sv
// Request, comparator, redirect and lookup signals of the branch resolution controller.
// The slave modport is the controller's view; master is its environment.
interface branch_resolve_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             i_valid;
   logic             o_ready;
   logic [31:0]      i_pc;
   logic [31:0]      i_imm;
   logic [2:0]       i_funct3;
   logic [31:0]      i_dataA;
   logic [31:0]      i_dataB;
   logic             i_pred_taken;
   logic [31:0]      o_cmpA;
   logic [31:0]      o_cmpB;
   logic             o_br_comp;
   logic             o_brUn;
   logic             i_brEq;
   logic             i_brLT;
   logic             o_redir_valid;
   logic             i_redir_ready;
   logic [31:0]      o_redir_pc;
   logic             o_flush;
   logic             o_illegal;
   logic [31:0]      i_lookup_pc;
   logic             o_lookup_taken;
   logic [CNT_W-1:0] o_mispred_cnt;

   modport slave (
      input  i_valid, i_pc, i_imm, i_funct3, i_dataA, i_dataB, i_pred_taken,
      input  i_brEq, i_brLT, i_redir_ready, i_lookup_pc,
      output o_ready, o_cmpA, o_cmpB, o_br_comp, o_brUn, o_redir_valid,
      output o_redir_pc, o_flush, o_illegal, o_lookup_taken, o_mispred_cnt
   );

   modport master (
      output i_valid, i_pc, i_imm, i_funct3, i_dataA, i_dataB, i_pred_taken,
      output i_brEq, i_brLT, i_redir_ready, i_lookup_pc,
      input  o_ready, o_cmpA, o_cmpB, o_br_comp, o_brUn, o_redir_valid,
      input  o_redir_pc, o_flush, o_illegal, o_lookup_taken, o_mispred_cnt
   );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Resolves one conditional branch at a time through an external comparator, trains a
// 2-bit branch history table and redirects fetch on a mispredict.
module branch_resolve_ctrl #(
   parameter int BHT_IDX_W = 4,
   parameter int CNT_W     = 16
) (
   input logic                  clk,
   input logic                  rst,
   branch_resolve_ctrl_if.slave bus
);
   localparam int BHT_N = 1 << BHT_IDX_W;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CMP     = 2'd1;
   localparam logic [1:0] RESOLVE = 2'd2;
   localparam logic [1:0] REDIR   = 2'd3;

   logic [1:0]           state_r;
   logic [1:0]           nextState_s;
   logic [31:0]          pc_r;
   logic [31:0]          imm_r;
   logic [2:0]           funct3_r;
   logic                 pred_r;
   logic [31:0]          cmpA_r;
   logic [31:0]          cmpB_r;
   logic                 brEq_r;
   logic                 brLT_r;
   logic                 ready_r;
   logic                 brComp_r;
   logic                 brUn_r;
   logic                 flush_r;
   logic                 illegal_r;
   logic                 redirValid_r;
   logic [31:0]          redirPc_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [1:0]           bht_r [BHT_N];
   logic                 legal_s;
   logic                 liveTaken_s;
   logic                 taken_s;
   logic [BHT_IDX_W-1:0] bhtIdx_s;
   logic [BHT_IDX_W-1:0] lookupIdx_s;
   logic                 unusedLookup_s;

   function automatic logic takenDecode(input logic [2:0] f3, input logic eq, input logic lt);
      case (f3)
         3'b000:         takenDecode = eq;
         3'b001:         takenDecode = !eq;
         3'b100, 3'b110: takenDecode = lt;
         3'b101, 3'b111: takenDecode = !lt;
         default:        takenDecode = 1'b0;
      endcase
   endfunction

   // Condition decode, table indices and next-state selection.
   always_comb begin
      legal_s     = (funct3_r[2:1] != 2'b01);
      liveTaken_s = legal_s && takenDecode(funct3_r, bus.i_brEq, bus.i_brLT);
      taken_s     = legal_s && takenDecode(funct3_r, brEq_r, brLT_r);
      bhtIdx_s    = pc_r[BHT_IDX_W+1:2];
      lookupIdx_s = bus.i_lookup_pc[BHT_IDX_W+1:2];
      nextState_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.i_valid) nextState_s = CMP;
            else             nextState_s = IDLE;
         end
         CMP: nextState_s = RESOLVE;
         RESOLVE: begin
            if (flush_r) nextState_s = REDIR;
            else         nextState_s = IDLE;
         end
         REDIR: begin
            if (bus.i_redir_ready) nextState_s = IDLE;
            else                   nextState_s = REDIR;
         end
         default: nextState_s = IDLE;
      endcase
   end

   // FSM, request latch and registered control outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         ready_r      <= 1'b1;
         brComp_r     <= 1'b0;
         brUn_r       <= 1'b0;
         flush_r      <= 1'b0;
         illegal_r    <= 1'b0;
         redirValid_r <= 1'b0;
         redirPc_r    <= 32'd0;
         pc_r         <= 32'd0;
         imm_r        <= 32'd0;
         funct3_r     <= 3'd0;
         pred_r       <= 1'b0;
         cmpA_r       <= 32'd0;
         cmpB_r       <= 32'd0;
         brEq_r       <= 1'b0;
         brLT_r       <= 1'b0;
      end else begin
         state_r      <= nextState_s;
         ready_r      <= (nextState_s == IDLE);
         brComp_r     <= (nextState_s == CMP);
         brUn_r       <= (nextState_s == CMP) && (bus.i_funct3[2:1] == 2'b11);
         redirValid_r <= (nextState_s == REDIR);
         // Flush is decided from the live comparator result so it lands in RESOLVE.
         flush_r      <= (state_r == CMP) && legal_s && (liveTaken_s != pred_r);
         illegal_r    <= (state_r == CMP) && !legal_s;
         if ((state_r == IDLE) && bus.i_valid) begin
            pc_r     <= bus.i_pc;
            imm_r    <= bus.i_imm;
            funct3_r <= bus.i_funct3;
            pred_r   <= bus.i_pred_taken;
            cmpA_r   <= bus.i_dataA;
            cmpB_r   <= bus.i_dataB;
         end
         if (state_r == CMP) begin
            brEq_r <= bus.i_brEq;
            brLT_r <= bus.i_brLT;
         end
         if ((state_r == RESOLVE) && flush_r) begin
            redirPc_r <= taken_s ? (pc_r + imm_r) : (pc_r + 32'd4);
         end
      end
   end

   // Saturating mispredict counter, stepped together with the flush decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == CMP) && legal_s && (liveTaken_s != pred_r) &&
                   (cnt_r != {CNT_W{1'b1}})) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Branch history table: 2-bit saturating counters trained in RESOLVE.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_N; i++) begin
            bht_r[i] <= 2'b01;
         end
      end else if ((state_r == RESOLVE) && legal_s) begin
         if (taken_s && (bht_r[bhtIdx_s] != 2'b11)) begin
            bht_r[bhtIdx_s] <= bht_r[bhtIdx_s] + 2'b01;
         end else if (!taken_s && (bht_r[bhtIdx_s] != 2'b00)) begin
            bht_r[bhtIdx_s] <= bht_r[bhtIdx_s] - 2'b01;
         end else begin
            bht_r[bhtIdx_s] <= bht_r[bhtIdx_s];
         end
      end
   end

   assign unusedLookup_s     = ^{bus.i_lookup_pc[31:BHT_IDX_W+2], bus.i_lookup_pc[1:0]};
   assign bus.o_lookup_taken = bht_r[lookupIdx_s][1];
   assign bus.o_ready        = ready_r;
   assign bus.o_cmpA         = cmpA_r;
   assign bus.o_cmpB         = cmpB_r;
   assign bus.o_br_comp      = brComp_r;
   assign bus.o_brUn         = brUn_r;
   assign bus.o_redir_valid  = redirValid_r;
   assign bus.o_redir_pc     = redirPc_r;
   assign bus.o_flush        = flush_r;
   assign bus.o_illegal      = illegal_r;
   assign bus.o_mispred_cnt  = cnt_r;
endmodule
